// File: rtl/ras_stack_pkg.sv
// Shared branch-predictor types for the return address stack, so pipeline
// registers downstream can carry a ras_ckpt_t alongside each instruction.
package ras_stack_pkg;

  localparam int unsigned RAS_DEPTH    = 8;
  localparam int unsigned RAS_PTR_W    = $clog2(RAS_DEPTH);
  localparam logic [31:0] RAS_LINK_OFS = 32'd8;

  typedef logic [31:0]          addr_t;
  typedef logic [RAS_PTR_W-1:0] ras_ptr_t;
  typedef logic [RAS_PTR_W:0]   ras_cnt_t;

  typedef struct packed {
    ras_ptr_t tos;
    ras_cnt_t count;
  } ras_ckpt_t;

  // Count saturates at DEPTH: a push onto a full stack recycles the oldest slot.
  function automatic ras_cnt_t cnt_inc_sat(ras_cnt_t c);
    return (c == ras_cnt_t'(RAS_DEPTH)) ? c : c + ras_cnt_t'(1);
  endfunction

endpackage

// File: rtl/ras_stack_if.sv
// Fetch/execute side of the return address stack: push/pop from f1,
// prediction + checkpoint back to f1, and the exe recovery port.
interface ras_stack_if;
  import ras_stack_pkg::*;

  logic      push_valid;
  addr_t     push_pc;
  logic      pop_valid;
  logic      pred_valid;
  addr_t     pred_pc;
  ras_ckpt_t ckpt;
  logic      recover_valid;
  ras_ckpt_t recover_ckpt;
  logic      recover_push;
  addr_t     recover_pc;

  modport master (
    output push_valid, push_pc, pop_valid,
    output recover_valid, recover_ckpt, recover_push, recover_pc,
    input  pred_valid, pred_pc, ckpt
  );

  modport slave (
    input  push_valid, push_pc, pop_valid,
    input  recover_valid, recover_ckpt, recover_push, recover_pc,
    output pred_valid, pred_pc, ckpt
  );

endinterface

// File: rtl/ras_stack.sv
// Speculative return address stack with a zero-latency top-of-stack read and
// checkpoint/restore of its pointers on an execute-stage mispredict.
module ras_stack
  import ras_stack_pkg::*;
#(
  parameter int unsigned DEPTH    = RAS_DEPTH,
  parameter addr_t       LINK_OFS = RAS_LINK_OFS
) (
  input  logic        clk,
  input  logic        reset,
  ras_stack_if.slave  bus
);

  addr_t    r_stack [DEPTH];
  ras_ptr_t r_tos;
  ras_cnt_t r_count;

  ras_ptr_t w_nxt_tos;
  ras_cnt_t w_nxt_count;
  logic     w_wr_en;
  ras_ptr_t w_wr_idx;
  addr_t    w_wr_data;

  assign bus.pred_pc    = r_stack[r_tos];
  assign bus.pred_valid = (r_count != '0);
  assign bus.ckpt       = '{tos: r_tos, count: r_count};

  always_comb begin
    // NOTE: every output gets a default first so no path through the ifs infers a latch.
    w_nxt_tos   = r_tos;
    w_nxt_count = r_count;
    w_wr_en     = 1'b0;
    w_wr_idx    = r_tos;
    w_wr_data   = bus.push_pc + LINK_OFS;

    if (bus.recover_valid) begin
      // f1 is being flushed, so its push/pop this cycle is deliberately dropped.
      w_nxt_tos   = bus.recover_ckpt.tos;
      w_nxt_count = bus.recover_ckpt.count;
      if (bus.recover_push) begin
        w_nxt_tos   = bus.recover_ckpt.tos + ras_ptr_t'(1);
        w_nxt_count = cnt_inc_sat(bus.recover_ckpt.count);
        w_wr_en     = 1'b1;
        w_wr_idx    = bus.recover_ckpt.tos + ras_ptr_t'(1);
        w_wr_data   = bus.recover_pc + LINK_OFS;
      end
    end else if (bus.push_valid && bus.pop_valid) begin
      w_wr_en     = 1'b1;
      w_nxt_count = (r_count == '0) ? ras_cnt_t'(1) : r_count;
    end else if (bus.push_valid) begin
      w_nxt_tos   = r_tos + ras_ptr_t'(1);
      w_nxt_count = cnt_inc_sat(r_count);
      w_wr_en     = 1'b1;
      w_wr_idx    = r_tos + ras_ptr_t'(1);
    end else if (bus.pop_valid && (r_count != '0)) begin
      w_nxt_tos   = r_tos - ras_ptr_t'(1);
      w_nxt_count = r_count - ras_cnt_t'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tos   <= '0;
      r_count <= '0;
      // NOTE: the array is reset (flops, not a RAM) so pred_pc reads 0 the instant reset asserts.
      for (int i = 0; i < int'(DEPTH); i++) r_stack[i] <= '0;
    end else begin
      // NOTE: non-blocking updates so every register samples the pre-edge state.
      r_tos   <= w_nxt_tos;
      r_count <= w_nxt_count;
      if (w_wr_en) r_stack[w_wr_idx] <= w_wr_data;
    end
  end

endmodule

// File: tb/tb_ras_stack.sv
// Self-checking bench for ras_stack: directed vector table, hand-written
// overflow/underflow and reset sequences, and random traffic against a model.
module tb_ras_stack;
  import ras_stack_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ras_stack_if bus ();
  ras_stack dut (.clk(clk), .reset(reset), .bus(bus));

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit    rst, push, pop;
    addr_t pc;
    bit    rec;
    int    rtos, rcnt;
    bit    rpush;
    addr_t rpc;
    bit    ev;
    addr_t epc;
    int    etos, ecnt;
  } vec_t;

  vec_t tbl[$];

  // Behavioural model: a circular array addressed by plain integer arithmetic.
  addr_t m_mem [RAS_DEPTH];
  int    m_tos, m_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag, input bit ev, input addr_t epc,
                             input int etos, input int ecnt);
    check({tag, ".valid"}, 32'(bus.pred_valid), 32'(ev));
    check({tag, ".pc"},    bus.pred_pc, epc);
    check({tag, ".tos"},   32'(bus.ckpt.tos), 32'(etos));
    check({tag, ".count"}, 32'(bus.ckpt.count), 32'(ecnt));
  endtask

  function automatic void model_reset();
    m_tos = 0;
    m_cnt = 0;
    for (int i = 0; i < RAS_DEPTH; i++) m_mem[i] = '0;
  endfunction

  function automatic void model_step(input vec_t s);
    int d = RAS_DEPTH;
    if (s.rec) begin
      m_tos = s.rtos;
      m_cnt = s.rcnt;
      if (s.rpush) begin
        m_tos = (m_tos + 1) % d;
        m_mem[m_tos] = s.rpc + 32'd8;
        m_cnt = (m_cnt + 1 > d) ? d : m_cnt + 1;
      end
    end else if (s.push && s.pop) begin
      m_mem[m_tos] = s.pc + 32'd8;
      if (m_cnt == 0) m_cnt = 1;
    end else if (s.push) begin
      m_tos = (m_tos + 1) % d;
      m_mem[m_tos] = s.pc + 32'd8;
      m_cnt = (m_cnt + 1 > d) ? d : m_cnt + 1;
    end else if (s.pop && m_cnt > 0) begin
      m_tos = (m_tos + d - 1) % d;
      m_cnt = m_cnt - 1;
    end
  endfunction

  task automatic idle_inputs();
    bus.push_valid    = 1'b0;
    bus.push_pc       = '0;
    bus.pop_valid     = 1'b0;
    bus.recover_valid = 1'b0;
    bus.recover_ckpt  = '0;
    bus.recover_push  = 1'b0;
    bus.recover_pc    = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
  endtask

  // One clock of stimulus; outputs are sampled 1ns after the edge.
  task automatic cycle(input vec_t s);
    if (s.rst) begin
      do_reset();
    end else begin
      bus.push_valid    = s.push;
      bus.push_pc       = s.pc;
      bus.pop_valid     = s.pop;
      bus.recover_valid = s.rec;
      bus.recover_ckpt  = '{tos: ras_ptr_t'(s.rtos), count: ras_cnt_t'(s.rcnt)};
      bus.recover_push  = s.rpush;
      bus.recover_pc    = s.rpc;
      @(posedge clk);
      #1 idle_inputs();
      model_step(s);
    end
  endtask

  task automatic add(input bit rst, push, pop, input addr_t pc, input bit rec,
                     input int rtos, rcnt, input bit rpush, input addr_t rpc,
                     input bit ev, input addr_t epc, input int etos, ecnt);
    vec_t v;
    v = '{rst, push, pop, pc, rec, rtos, rcnt, rpush, rpc, ev, epc, etos, ecnt};
    tbl.push_back(v);
  endtask

  function automatic vec_t op(input bit push, pop, input addr_t pc);
    vec_t v = '{default: 0};
    v.push = push; v.pop = pop; v.pc = pc;
    return v;
  endfunction

  initial begin
    ras_ckpt_t hist[$];
    vec_t      s;

    reset = 1'b1;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check_state("reset", 0, 32'h0, 0, 0);

    //   rst push pop pc            rec rtos rcnt rpush rpc          ev pc            tos cnt
    add(0, 1, 0, 32'hBFC00100, 0, 0, 0, 0, 32'h0,    1, 32'hBFC00108, 1, 1);
    add(0, 0, 1, 32'h0,        0, 0, 0, 0, 32'h0,    0, 32'h0,        0, 0);
    add(0, 1, 0, 32'h100,      0, 0, 0, 0, 32'h0,    1, 32'h108,      1, 1);
    add(0, 1, 1, 32'h300,      0, 0, 0, 0, 32'h0,    1, 32'h308,      1, 1);
    add(0, 0, 1, 32'h0,        0, 0, 0, 0, 32'h0,    0, 32'h0,        0, 0);
    add(0, 1, 1, 32'h400,      0, 0, 0, 0, 32'h0,    1, 32'h408,      0, 1);
    add(1, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,    0, 32'h0,        0, 0);
    add(0, 1, 0, 32'h500,      0, 0, 0, 0, 32'h0,    1, 32'h508,      1, 1);
    add(0, 1, 0, 32'h600,      0, 0, 0, 0, 32'h0,    1, 32'h608,      2, 2);
    add(0, 0, 1, 32'h0,        0, 0, 0, 0, 32'h0,    1, 32'h508,      1, 1);
    add(0, 0, 1, 32'h0,        0, 0, 0, 0, 32'h0,    0, 32'h0,        0, 0);
    add(0, 0, 1, 32'h0,        0, 0, 0, 0, 32'h0,    0, 32'h0,        0, 0);
    add(0, 1, 0, 32'h700,      0, 0, 0, 0, 32'h0,    1, 32'h708,      1, 1);
    add(0, 1, 0, 32'h900,      1, 2, 2, 0, 32'h0,    1, 32'h608,      2, 2);
    add(0, 1, 0, 32'hA00,      0, 0, 0, 0, 32'h0,    1, 32'hA08,      3, 3);
    add(0, 0, 1, 32'h0,        0, 0, 0, 0, 32'h0,    1, 32'h608,      2, 2);
    add(0, 0, 1, 32'h0,        1, 3, 3, 1, 32'h1000, 1, 32'h1008,     4, 4);
    add(0, 1, 0, 32'hFFFFFFFC, 0, 0, 0, 0, 32'h0,    1, 32'h4,        5, 5);

    foreach (tbl[i]) begin
      cycle(tbl[i]);
      check_state($sformatf("vec%0d", i), tbl[i].ev, tbl[i].epc, tbl[i].etos, tbl[i].ecnt);
    end

    // Overflow: nine calls into an eight-deep stack, then drain past empty.
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      cycle(op(1, 0, 32'(i * 32'h100)));
      check($sformatf("ovf_push%0d.pc", i), bus.pred_pc, 32'(i * 32'h100 + 8));
      check($sformatf("ovf_push%0d.count", i), 32'(bus.ckpt.count), 32'((i > 8) ? 8 : i));
    end
    for (int k = 1; k <= 8; k++) begin
      check($sformatf("ovf_pop%0d.pc", k), bus.pred_pc, 32'((10 - k) * 32'h100 + 8));
      cycle(op(0, 1, 32'h0));
    end
    check("ovf_empty.valid", 32'(bus.pred_valid), 32'd0);
    cycle(op(0, 1, 32'h0));
    check("ovf_underflow.tos", 32'(bus.ckpt.tos), 32'd1);
    check("ovf_underflow.count", 32'(bus.ckpt.count), 32'd0);

    // Async reset arriving mid-cycle while a push is presented.
    cycle(op(1, 0, 32'h2000));
    bus.push_valid = 1'b1;
    bus.push_pc    = 32'h3000;
    @(negedge clk);
    reset = 1'b1;
    #1 check_state("async_rst", 0, 32'h0, 0, 0);
    @(posedge clk);
    #1 check_state("rst_hold", 0, 32'h0, 0, 0);
    idle_inputs();
    reset = 1'b0;
    model_reset();
    cycle(op(0, 0, 32'h0));
    check_state("rst_release", 0, 32'h0, 0, 0);

    // Random traffic, recovering to checkpoints recorded by the model.
    for (int n = 0; n < 600; n++) begin
      int r;
      s = '{default: 0};
      r = $urandom_range(0, 19);
      if (r == 0 && hist.size() > 0) begin
        ras_ckpt_t c = hist[$urandom_range(0, hist.size() - 1)];
        s.rec   = 1;
        s.rtos  = int'(c.tos);
        s.rcnt  = int'(c.count);
        s.rpush = 1'($urandom_range(0, 1));
        s.rpc   = $urandom;
        s.push  = 1'($urandom_range(0, 1));
        s.pop   = 1'($urandom_range(0, 1));
      end else begin
        s.push = (r < 10);
        s.pop  = (r >= 7 && r < 17);
      end
      s.pc = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFF8 + 32'($urandom_range(0, 7)) : $urandom;
      hist.push_back('{tos: ras_ptr_t'(m_tos), count: ras_cnt_t'(m_cnt)});
      if (hist.size() > 6) void'(hist.pop_front());
      cycle(s);
      check_state($sformatf("rnd%0d", n), m_cnt != 0, m_mem[m_tos], m_tos, m_cnt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
